traffic_ctrl_multi: RTL

Parametrised successor to the two-road traffic-light FSM. It sequences green, yellow and all-red phases across NUM_APPR approaches; approach 0 is the main road. It has an integrated tick-driven phase timer, so no external timer or interval handshake is needed. It adds sticky pedestrian-walk latching, optional demand-skipping of idle side approaches, an all-red clearance phase, and a flash (fault) mode. It sits between the input synchronisers and the lamp drivers.

---
 rtl/traffic_ctrl_multi.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/traffic_ctrl_multi.sv
// Multi-approach traffic-light sequencer (green/extension/yellow/all-red/walk/flash) with tick-driven phase timer.
// Latency: lamps are decoded from registered state only, so they change one clock after the causing input.
// Backpressure: none; tick_i, sensor_i, walk_req_i, prog_i and flash_mode_i are sampled on every clock.
// Ports: clk_i, rst_i (async, active high), tick_i timebase pulse, sensor_i per-approach demand,
//        walk_req_i pedestrian request, prog_i synchronous restart, flash_mode_i fault request;
//        red_o/yel_o/grn_o lamp drives, walk_o walk lamp, walk_ack_o walk-entry pulse, active_o served approach.
module traffic_ctrl_multi #(
  parameter int NUM_APPR  = 3,
  parameter int CNT_W     = 8,
  parameter int BASE_T    = 6,
  parameter int EXT_T     = 3,
  parameter int YEL_T     = 2,
  parameter int ALLRED_T  = 1,
  parameter int WALK_T    = 3,
  parameter int SKIP_IDLE = 1,
  localparam int IDX_W    = (NUM_APPR > 2) ? $clog2(NUM_APPR) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                tick_i,
  input  logic [NUM_APPR-1:0] sensor_i,
  input  logic                walk_req_i,
  input  logic                prog_i,
  input  logic                flash_mode_i,
  output logic [NUM_APPR-1:0] red_o,
  output logic [NUM_APPR-1:0] yel_o,
  output logic [NUM_APPR-1:0] grn_o,
  output logic                walk_o,
  output logic                walk_ack_o,
  output logic [IDX_W-1:0]    active_o
);

  typedef enum logic [2:0] {
    S_GREEN_BASE,
    S_GREEN_EXT,
    S_YELLOW,
    S_ALL_RED,
    S_WALK,
    S_FLASH
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cur_q, cur_d;
  logic [IDX_W-1:0] nxt_q, nxt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             walk_pending_q, walk_pending_d;
  logic             flash_ph_q, flash_ph_d;
  logic             walk_ack_q, walk_ack_d;
  logic             expire;
  logic             enter_walk;
  logic [IDX_W-1:0] scan_appr;
  int               scan_idx;

  // Next approach after cur. Scanning from the farthest offset towards the
  // nearest lets the nearest qualifying candidate overwrite the rest; a hit on
  // approach 0 overwrites everything beyond it, so the main road is never passed.
  always_comb begin
    scan_appr = '0;
    scan_idx  = 0;
    for (int off = NUM_APPR - 1; off >= 1; off--) begin
      scan_idx = (int'(cur_q) + off) % NUM_APPR;
      if (scan_idx == 0 || SKIP_IDLE == 0 || sensor_i[IDX_W'(scan_idx)]) begin
        scan_appr = IDX_W'(scan_idx);
      end
    end
  end

  // The expiring tick is consumed by the transition: the new state's count is
  // loaded instead of decremented, so each phase lasts exactly its tick count.
  assign expire = tick_i && (cnt_q == CNT_W'(1));

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    nxt_d      = nxt_q;
    cnt_d      = cnt_q;
    enter_walk = 1'b0;
    if (flash_mode_i) begin
      state_d = S_FLASH;
    end else if (state_q == S_FLASH) begin
      state_d = S_ALL_RED;
      cnt_d   = CNT_W'(ALLRED_T);
      cur_d   = '0;
      nxt_d   = '0;
    end else if (expire) begin
      case (state_q)
        S_GREEN_BASE: begin
          if (sensor_i[cur_q]) begin
            state_d = S_GREEN_EXT;
            cnt_d   = CNT_W'(EXT_T);
          end else begin
            state_d = S_YELLOW;
            cnt_d   = CNT_W'(YEL_T);
          end
        end
        S_GREEN_EXT: begin
          state_d = S_YELLOW;
          cnt_d   = CNT_W'(YEL_T);
        end
        S_YELLOW: begin
          state_d = S_ALL_RED;
          cnt_d   = CNT_W'(ALLRED_T);
          nxt_d   = scan_appr;
        end
        S_ALL_RED: begin
          if (walk_pending_q) begin
            state_d    = S_WALK;
            cnt_d      = CNT_W'(WALK_T);
            enter_walk = 1'b1;
          end else begin
            state_d = S_GREEN_BASE;
            cnt_d   = CNT_W'(BASE_T);
            cur_d   = nxt_q;
          end
        end
        S_WALK: begin
          state_d = S_GREEN_BASE;
          cnt_d   = CNT_W'(BASE_T);
          cur_d   = nxt_q;
        end
        default: ;
      endcase
    end else if (tick_i) begin
      cnt_d = cnt_q - CNT_W'(1);
    end

    // A request arriving on the walk-entry clock survives the clear.
    walk_pending_d = walk_req_i | (walk_pending_q & ~enter_walk);
    walk_ack_d     = enter_walk;
    flash_ph_d     = flash_ph_q ^ ((state_q == S_FLASH) && tick_i);

    if (prog_i) begin
      state_d        = S_GREEN_BASE;
      cur_d          = '0;
      nxt_d          = '0;
      cnt_d          = CNT_W'(BASE_T);
      walk_pending_d = 1'b0;
      walk_ack_d     = 1'b0;
      flash_ph_d     = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= S_GREEN_BASE;
      cur_q          <= '0;
      nxt_q          <= '0;
      cnt_q          <= CNT_W'(BASE_T);
      walk_pending_q <= 1'b0;
      walk_ack_q     <= 1'b0;
      flash_ph_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cur_q          <= cur_d;
      nxt_q          <= nxt_d;
      cnt_q          <= cnt_d;
      walk_pending_q <= walk_pending_d;
      walk_ack_q     <= walk_ack_d;
      flash_ph_q     <= flash_ph_d;
    end
  end

  // Output decode from registered state only
  always_comb begin
    red_o  = '1;
    yel_o  = '0;
    grn_o  = '0;
    walk_o = 1'b0;
    case (state_q)
      S_GREEN_BASE, S_GREEN_EXT: begin
        red_o[cur_q] = 1'b0;
        grn_o[cur_q] = 1'b1;
      end
      S_YELLOW: begin
        red_o[cur_q] = 1'b0;
        yel_o[cur_q] = 1'b1;
      end
      S_WALK: walk_o = 1'b1;
      S_FLASH: begin
        // Main road flashes amber, side roads flash red, in phase.
        red_o    = {{(NUM_APPR-1){flash_ph_q}}, 1'b0};
        yel_o[0] = flash_ph_q;
      end
      default: ;
    endcase
  end

  assign walk_ack_o = walk_ack_q;
  assign active_o   = cur_q;

endmodule
